// File: rtl/zbb_iter_ctrl.sv
// zbb_iter_ctrl -- multi-cycle sequencer for the Zbb count ops clz, ctz and cpop.
//
// The instruction is decoded combinationally. On a match in IDLE the rs1
// operand is captured and scanned STEP bits per RUN cycle, while the core is
// held with stall. The count is presented for one DONE cycle with regWrite.
// clz and ctz leave RUN early on the first nonzero chunk. cpop always
// scans all 32/STEP chunks.
//
// Ports
//   clk           core clock
//   rst_n         synchronous active-low reset
//   cmdOp/F3/F7   opcode, funct3 and funct7 fields of the current instruction
//   cmdRs2        rs2 field, which selects clz/ctz/cpop
//   din_rs1       rs1 operand, held stable by the core while stall=1
//   dout_rd       zero-extended count. It is nonzero only while regWrite=1
//   regWrite      one-cycle rd write strobe
//   isZbbMcInstr  current instruction is clz/ctz/cpop
//   stall         hold PC and instruction
//   busy          sequencer is not IDLE

// Per-chunk counters: population count, leading zeros and trailing zeros.
// An all-zero chunk reports STEP for both zero counts.
module zbb_chunk_cnt #(
  parameter int STEP = 4,
  parameter int CW   = $clog2(STEP + 1)
) (
  input  logic [STEP-1:0] chunk,
  output logic [CW-1:0]   pop,
  output logic [CW-1:0]   lz,
  output logic [CW-1:0]   tz
);
  always_comb begin
    pop = '0;
    for (int i = 0; i < STEP; i++) pop = pop + CW'(chunk[i]);
  end

  always_comb begin
    logic seen;
    lz   = CW'(STEP);
    seen = 1'b0;
    for (int i = STEP - 1; i >= 0; i--) begin
      if (!seen && chunk[i]) begin
        lz   = CW'(STEP - 1 - i);
        seen = 1'b1;
      end
    end
  end

  always_comb begin
    logic seen;
    tz   = CW'(STEP);
    seen = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (!seen && chunk[i]) begin
        tz   = CW'(i);
        seen = 1'b1;
      end
    end
  end
endmodule

module zbb_iter_ctrl #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  cmdOp,
  input  logic [2:0]  cmdF3,
  input  logic [6:0]  cmdF7,
  input  logic [4:0]  cmdRs2,
  input  logic [31:0] din_rs1,
  output logic [31:0] dout_rd,
  output logic        regWrite,
  output logic        isZbbMcInstr,
  output logic        stall,
  output logic        busy
);
  localparam int NCH  = 32 / STEP;
  localparam int CNTW = (NCH < 2) ? 1 : $clog2(NCH + 1);
  localparam int CW   = $clog2(STEP + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_CLZ, OP_CTZ, OP_CPOP} op_t;

  state_t          state;
  op_t             opReg;
  op_t             decOp;
  logic [31:0]     opnd;
  logic [5:0]      acc;
  logic [CNTW-1:0] cnt;

  // Decode
  always_comb begin
    isZbbMcInstr = (cmdOp == 7'b0010011) && (cmdF3 == 3'b001) &&
                   (cmdF7 == 7'b0110000) && (cmdRs2[4:2] == 3'b000) &&
                   (cmdRs2[1:0] != 2'b11);
    case (cmdRs2[1:0])
      2'b00:   decOp = OP_CLZ;
      2'b01:   decOp = OP_CTZ;
      default: decOp = OP_CPOP;
    endcase
  end

  // clz consumes the operand from the top and shifts left. ctz and cpop
  // consume it from the bottom and shift right.
  logic [STEP-1:0] chunk;
  logic [CW-1:0]   cPop, cLz, cTz;
  logic [5:0]      addVal;
  logic            chunkNz, lastChunk, exitNow;

  assign chunk = (opReg == OP_CLZ) ? opnd[31 -: STEP] : opnd[STEP-1:0];

  zbb_chunk_cnt #(.STEP(STEP), .CW(CW)) uCnt (
    .chunk (chunk),
    .pop   (cPop),
    .lz    (cLz),
    .tz    (cTz)
  );

  always_comb begin
    chunkNz   = |chunk;
    lastChunk = (cnt == CNTW'(NCH - 1));
    addVal    = 6'(STEP);
    if (opReg == OP_CPOP)    addVal = 6'(cPop);
    else if (chunkNz)        addVal = 6'((opReg == OP_CLZ) ? cLz : cTz);
    // A nonzero chunk finishes clz/ctz, because the zero run has ended.
    exitNow   = lastChunk || ((opReg != OP_CPOP) && chunkNz);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      opReg <= OP_CLZ;
      opnd  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (isZbbMcInstr) begin
            opnd  <= din_rs1;
            opReg <= decOp;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= acc + addVal;
          cnt  <= cnt + 1'b1;
          opnd <= (opReg == OP_CLZ) ? (opnd << STEP) : (opnd >> STEP);
          if (exitNow) state <= DONE;
        end
        // Leave unconditionally. The instruction is still on the inputs
        // this cycle and must not start a second operation.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state directly, so the result leaves in the DONE
  // cycle itself. Reset masks them immediately.
  assign busy     = rst_n && (state != IDLE);
  assign stall    = rst_n && (((state == IDLE) && isZbbMcInstr) || (state == RUN));
  assign regWrite = rst_n && (state == DONE);
  assign dout_rd  = regWrite ? {26'b0, acc} : 32'b0;
endmodule

// File: tb/tb_zbb_iter_ctrl.sv
module tb_zbb_iter_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  cmdOp;
  logic [2:0]  cmdF3;
  logic [6:0]  cmdF7;
  logic [4:0]  cmdRs2;
  logic [31:0] din_rs1;
  logic [31:0] dout_rd;
  logic        regWrite, isZbbMcInstr, stall, busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  zbb_iter_ctrl #(.STEP(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmdOp        (cmdOp),
    .cmdF3        (cmdF3),
    .cmdF7        (cmdF7),
    .cmdRs2       (cmdRs2),
    .din_rs1      (din_rs1),
    .dout_rd      (dout_rd),
    .regWrite     (regWrite),
    .isZbbMcInstr (isZbbMcInstr),
    .stall        (stall),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs2;
    logic [31:0] rs1;
    bit          expIs;
    logic [31:0] expRes;
    int          expK;
  } vec_t;

  function automatic vec_t cnt(string n, logic [4:0] rs2, logic [31:0] rs1,
                               logic [31:0] res, int k);
    vec_t v;
    v.name = n; v.op = 7'b0010011; v.f3 = 3'b001; v.f7 = 7'b0110000;
    v.rs2 = rs2; v.rs1 = rs1; v.expIs = 1'b1; v.expRes = res; v.expK = k;
    return v;
  endfunction

  function automatic vec_t other(string n, logic [6:0] op, logic [2:0] f3,
                                 logic [6:0] f7, logic [4:0] rs2);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.rs2 = rs2;
    v.rs1 = 32'hDEAD_BEEF; v.expIs = 1'b0; v.expRes = '0; v.expK = 0;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", n, act, act, exp, exp);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest expected result.
  always @(negedge clk) begin
    if (regWrite) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_regwrite: dout_rd=%0d with nothing expected", dout_rd);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (dout_rd !== e) begin
          errors++;
          $display("FAIL dout_rd: got %0d, expected %0d", dout_rd, e);
        end
      end
    end
  end

  // Called just after a rising edge. Drives one instruction and follows it
  // to completion, then returns just after the edge that leaves DONE.
  task automatic runOp(input vec_t v);
    int stallCnt;
    bit got;
    cmdOp = v.op; cmdF3 = v.f3; cmdF7 = v.f7; cmdRs2 = v.rs2; din_rs1 = v.rs1;
    if (v.expIs) sb.push_back(v.expRes);
    stallCnt = 0;
    got = 1'b0;
    @(negedge clk);
    chk({v.name, " decode"}, 32'(isZbbMcInstr), 32'(v.expIs));
    if (v.expIs) begin
      chk({v.name, " idle_stall"}, 32'(stall), 32'd1);
      chk({v.name, " idle_busy"}, 32'(busy), 32'd0);
      for (int c = 0; c < 40 && !got; c++) begin
        if (regWrite) begin
          got = 1'b1;
          chk({v.name, " done_stall"}, 32'(stall), 32'd0);
          chk({v.name, " done_busy"}, 32'(busy), 32'd1);
        end else begin
          if (stall) stallCnt++;
          @(negedge clk);
        end
      end
      chk({v.name, " completed"}, 32'(got), 32'd1);
      chk({v.name, " stall_cycles"}, 32'(stallCnt), 32'(1 + v.expK));
    end else begin
      for (int c = 0; c < 4; c++) begin
        chk({v.name, " stall"}, 32'(stall), 32'd0);
        chk({v.name, " regWrite"}, 32'(regWrite), 32'd0);
        chk({v.name, " busy"}, 32'(busy), 32'd0);
        if (c < 3) @(negedge clk);
      end
    end
    @(posedge clk); #1;
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back(cnt("cpop_f0f00001", 5'd2, 32'hF0F0_0001, 32'd9, 8));
    vecs.push_back(cnt("clz_zero", 5'd0, 32'h0000_0000, 32'd32, 8));
    vecs.push_back(cnt("ctz_zero", 5'd1, 32'h0000_0000, 32'd32, 8));
    vecs.push_back(cnt("clz_msb", 5'd0, 32'h8000_0000, 32'd0, 1));
    vecs.push_back(cnt("ctz_bit16", 5'd1, 32'h0001_0000, 32'd16, 5));
    vecs.push_back(cnt("clz_bit8", 5'd0, 32'h0000_0100, 32'd23, 6));
    vecs.push_back(cnt("ctz_msb", 5'd1, 32'h8000_0000, 32'd31, 8));
    vecs.push_back(cnt("clz_lsb", 5'd0, 32'h0000_0001, 32'd31, 8));
    vecs.push_back(cnt("ctz_6", 5'd1, 32'h0000_0006, 32'd1, 1));
    vecs.push_back(cnt("cpop_ones", 5'd2, 32'hFFFF_FFFF, 32'd32, 8));
    vecs.push_back(cnt("cpop_zero", 5'd2, 32'h0000_0000, 32'd0, 8));
    vecs.push_back(other("andn", 7'b0110011, 3'b111, 7'b0100000, 5'd2));
    vecs.push_back(other("clz_rs2_3", 7'b0010011, 3'b001, 7'b0110000, 5'd3));
    vecs.push_back(other("bad_f3", 7'b0010011, 3'b101, 7'b0110000, 5'd0));
    vecs.push_back(other("bad_rs2_hi", 7'b0010011, 3'b001, 7'b0110000, 5'd16));

    // Reset with a count instruction already on the inputs.
    rst_n = 1'b0;
    cmdOp = 7'b0010011; cmdF3 = 3'b001; cmdF7 = 7'b0110000; cmdRs2 = 5'd0;
    din_rs1 = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset regWrite", 32'(regWrite), 32'd0);
    chk("reset dout_rd", dout_rd, 32'd0);
    chk("reset decode", 32'(isZbbMcInstr), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) runOp(vecs[i]);

    // Reset during the third RUN cycle of cpop aborts without a write.
    cmdOp = 7'b0010011; cmdF3 = 3'b001; cmdF7 = 7'b0110000; cmdRs2 = 5'd2;
    din_rs1 = 32'hFFFF_FFFF;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("abort run_stall", 32'(stall), 32'd1);
    chk("abort run_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort forced_stall", 32'(stall), 32'd0);
    chk("abort forced_busy", 32'(busy), 32'd0);
    chk("abort forced_regWrite", 32'(regWrite), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    runOp(cnt("cpop_after_reset", 5'd2, 32'hFFFF_FFFF, 32'd32, 8));

    // Back-to-back: the second op must stall from the first cycle after DONE.
    runOp(cnt("b2b_clz", 5'd0, 32'h00F0_0000, 32'd8, 3));
    runOp(cnt("b2b_cpop", 5'd2, 32'h1234_5678, 32'd13, 8));

    cmdOp = 7'b0110011; cmdF3 = 3'b111; cmdF7 = 7'b0100000; cmdRs2 = 5'd0;
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
